// File: rtl/hdlc_pkg.sv
// Shared HDLC register map, status/control bit positions and host-controller state encoding.
package hdlc_pkg;

  localparam logic [2:0] ADDR_TX_SC   = 3'd0;
  localparam logic [2:0] ADDR_TX_BUFF = 3'd1;
  localparam logic [2:0] ADDR_RX_SC   = 3'd2;
  localparam logic [2:0] ADDR_RX_BUFF = 3'd3;
  localparam logic [2:0] ADDR_RX_LEN  = 3'd4;

  localparam int unsigned TX_DONE_BIT      = 0;
  localparam int unsigned TX_ENABLE_BIT    = 1;
  localparam int unsigned TX_ABORT_BIT     = 2;

  localparam int unsigned RX_READY_BIT     = 0;
  localparam int unsigned RX_DROP_BIT      = 1;
  localparam int unsigned RX_FRAME_ERR_BIT = 2;
  localparam int unsigned RX_ABORT_BIT     = 3;
  localparam int unsigned RX_OVERFLOW_BIT  = 4;

  localparam int unsigned MAX_TX_LEN_DEF = 126;

  localparam logic [7:0] TX_GO_CMD   = 8'(1 << TX_ENABLE_BIT);
  localparam logic [7:0] RX_DROP_CMD = 8'(1 << RX_DROP_BIT);

  typedef enum logic [3:0] {
    IDLE,
    RX_POLL,
    RX_STAT,
    RX_LEN,
    RX_RD,
    RX_DROP,
    TX_CHK,
    TX_STAT,
    TX_WR,
    TX_GO
  } state_t;

endpackage

// File: rtl/hdlc_host_ctrl.sv
// Host-side HDLC register sequencer: polls RX/TX status, streams RX bytes out
// and TX bytes in through the controller's byte-wide register interface.
module hdlc_host_ctrl
  import hdlc_pkg::*;
#(
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned MAX_TX_LEN = MAX_TX_LEN_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic       ReadEnable,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       rx_err,
  input  logic       rx_ready,
  output logic       tx_len_err,
  output logic       busy
);

  state_t      state, state_nxt;
  logic [15:0] gap_cnt;
  logic        gap_done;
  logic        rx_first;
  logic        len_ph;
  logic [2:0]  err_flags;
  logic [7:0]  rx_len;
  logic [7:0]  rd_cnt;
  logic [7:0]  rcv_cnt;
  logic [7:0]  tx_cnt;
  logic        rd_pend;
  logic        rx_accept;
  logic        rx_issue;
  logic        rcv_is_last;
  logic        tx_room;
  logic        drop_frame;

  assign gap_done    = (32'(gap_cnt) + 32'd1 >= POLL_GAP);
  assign rx_accept   = rx_valid && rx_ready;
  // Only one Rx_Buff read outstanding, and only when its byte has somewhere to land.
  assign rx_issue    = (state == RX_RD) && !rd_pend && (rd_cnt < rx_len) &&
                       (!rx_valid || rx_accept);
  assign rcv_is_last = ((rcv_cnt + 8'd1) == rx_len);
  assign tx_room     = (32'(tx_cnt) < MAX_TX_LEN);
  // Frame/abort errors drop the frame; overflow frames are delivered and flagged via rx_err.
  assign drop_frame  = (DataOut == 8'd0) || err_flags[0] || err_flags[1];
  assign busy        = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    Address     = ADDR_TX_SC;
    WriteEnable = 1'b0;
    ReadEnable  = 1'b0;
    DataIn      = '0;
    tx_ready    = 1'b0;
    tx_len_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gap_done) state_nxt = (!rx_first && tx_valid) ? TX_CHK : RX_POLL;
      end
      RX_POLL: begin
        Address    = ADDR_RX_SC;
        ReadEnable = 1'b1;
        state_nxt  = RX_STAT;
      end
      RX_STAT: begin
        Address   = ADDR_RX_SC;
        state_nxt = DataOut[RX_READY_BIT] ? RX_LEN : IDLE;
      end
      RX_LEN: begin
        // First cycle issues the Rx_Len read, second cycle samples it.
        Address    = ADDR_RX_LEN;
        ReadEnable = !len_ph;
        if (len_ph) state_nxt = drop_frame ? RX_DROP : RX_RD;
      end
      RX_DROP: begin
        Address     = ADDR_RX_SC;
        WriteEnable = 1'b1;
        DataIn      = RX_DROP_CMD;
        state_nxt   = IDLE;
      end
      RX_RD: begin
        Address    = ADDR_RX_BUFF;
        ReadEnable = rx_issue;
        if (rx_accept && rx_last) state_nxt = IDLE;
      end
      TX_CHK: begin
        Address    = ADDR_TX_SC;
        ReadEnable = 1'b1;
        state_nxt  = TX_STAT;
      end
      TX_STAT: begin
        Address   = ADDR_TX_SC;
        state_nxt = DataOut[TX_DONE_BIT] ? TX_WR : IDLE;
      end
      TX_WR: begin
        Address     = ADDR_TX_BUFF;
        tx_ready    = 1'b1;
        DataIn      = tx_data;
        WriteEnable = tx_valid && tx_room;
        tx_len_err  = tx_valid && tx_last && !tx_room;
        if (tx_valid && tx_last) state_nxt = TX_GO;
      end
      TX_GO: begin
        Address     = ADDR_TX_SC;
        WriteEnable = 1'b1;
        DataIn      = TX_GO_CMD;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      gap_cnt   <= '0;
      rx_first  <= 1'b1;
      len_ph    <= 1'b0;
      err_flags <= '0;
      rx_len    <= '0;
      rd_cnt    <= '0;
      rcv_cnt   <= '0;
      rd_pend   <= 1'b0;
      tx_cnt    <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_last   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      gap_cnt <= (state == IDLE && !gap_done) ? gap_cnt + 16'd1 : '0;

      if (state == RX_POLL)     rx_first <= 1'b0;
      else if (state == TX_CHK) rx_first <= 1'b1;

      if (state == RX_STAT) err_flags <= DataOut[RX_OVERFLOW_BIT:RX_FRAME_ERR_BIT];
      len_ph <= (state == RX_LEN) && !len_ph;

      if (state == RX_LEN && len_ph) begin
        rx_len  <= DataOut;
        rd_cnt  <= '0;
        rcv_cnt <= '0;
        rd_pend <= 1'b0;
      end else begin
        rd_pend <= rx_issue;
        if (rx_issue) rd_cnt  <= rd_cnt + 8'd1;
        if (rd_pend)  rcv_cnt <= rcv_cnt + 8'd1;
      end

      if (rd_pend) begin
        rx_valid <= 1'b1;
        rx_data  <= DataOut;
        rx_last  <= rcv_is_last;
        rx_err   <= rcv_is_last && err_flags[2];
      end else if (rx_accept) begin
        rx_valid <= 1'b0;
        rx_last  <= 1'b0;
        rx_err   <= 1'b0;
      end

      if (state == TX_STAT)                          tx_cnt <= '0;
      else if (state == TX_WR && tx_valid && tx_room) tx_cnt <= tx_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hdlc_host_ctrl.sv
// Scoreboard bench for hdlc_host_ctrl against a behavioural HDLC register model.
module tb_hdlc_host_ctrl;

  localparam int unsigned GAP    = 4;
  localparam int unsigned MAXLEN = 126;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [2:0] Address;
  logic       WriteEnable, ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut = 8'h00;
  logic       tx_valid, tx_last, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_last, rx_err, rx_ready;
  logic [7:0] rx_data;
  logic       tx_len_err, busy;

  hdlc_host_ctrl #(.POLL_GAP(GAP), .MAX_TX_LEN(MAXLEN)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .WriteEnable(WriteEnable),
    .ReadEnable(ReadEnable), .DataIn(DataIn), .DataOut(DataOut),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last), .rx_err(rx_err),
    .rx_ready(rx_ready), .tx_len_err(tx_len_err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_wr[$];   // {addr, data}
  logic [9:0]  exp_rx[$];   // {err, last, data}
  int          exp_lenerr = 0;
  int          rd3_cnt = 0;
  int          txr_cnt = 0;
  logic [2:0]  rd_log[$];

  logic [7:0] m_tx_sc = 8'h00;
  logic [7:0] m_rx_sc = 8'h00;
  logic [7:0] m_rx_len = 8'h00;
  logic [7:0] m_rx_bytes [256];
  int         frame_seq = 0;
  bit         rdy_rand = 1'b0;
  bit         rdy_hold = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // HDLC register file: read data appears the cycle after ReadEnable.
  initial begin : hdlc_model
    int seen_seq, rd_idx, idx;
    bit cleared, clr;
    seen_seq = 0; rd_idx = 0; cleared = 1'b0;
    forever begin
      @(posedge Clk);
      idx = (seen_seq == frame_seq) ? rd_idx : 0;
      clr = (seen_seq == frame_seq) ? cleared : 1'b0;
      seen_seq = frame_seq;
      if (ReadEnable) begin
        case (Address)
          3'd0: DataOut <= m_tx_sc;
          3'd2: DataOut <= clr ? 8'h00 : m_rx_sc;
          3'd3: begin
            DataOut <= m_rx_bytes[idx[7:0]];
            idx++;
            if (idx >= int'(m_rx_len)) clr = 1'b1;
          end
          3'd4: DataOut <= m_rx_len;
          default: DataOut <= 8'h00;
        endcase
      end
      if (WriteEnable && Address == 3'd2 && DataIn[1]) clr = 1'b1;
      rd_idx  = idx;
      cleared = clr;
    end
  end

  initial begin : ready_driver
    rx_ready = 1'b1;
    forever begin
      @(posedge Clk); #1;
      rx_ready = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom % 3 != 0) : 1'b1);
    end
  end

  initial begin : monitor
    logic [10:0] ew;
    logic [9:0]  er;
    bit          have;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        if (ReadEnable) begin
          rd_log.push_back(Address);
          if (Address == 3'd3) rd3_cnt++;
        end
        if (tx_ready) txr_cnt++;
        if (WriteEnable) begin
          have = (exp_wr.size() > 0);
          ew = have ? exp_wr.pop_front() : 11'h7FF;
          chk(have && {Address, DataIn} == ew && !ReadEnable, "reg_write",
              {ReadEnable, Address, DataIn}, ew);
        end
        if (rx_valid && rx_ready) begin
          have = (exp_rx.size() > 0);
          er = have ? exp_rx.pop_front() : 10'h3FF;
          chk(have && {rx_err, rx_last, rx_data} == er, "rx_byte",
              {rx_err, rx_last, rx_data}, er);
        end
        if (tx_len_err) begin
          chk(exp_lenerr > 0 && tx_valid && tx_ready && tx_last, "tx_len_err",
              {tx_valid, tx_ready, tx_last}, 7);
          if (exp_lenerr > 0) exp_lenerr--;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle();
    repeat (3 * GAP + 20) @(posedge Clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_rx.size() != 0 || exp_lenerr != 0) && n < 4000) begin
      @(posedge Clk);
      n++;
    end
    chk(n < 4000, {name, "_drain"}, exp_wr.size() + exp_rx.size() + exp_lenerr, 0);
    settle();
  endtask

  // Expectation: length 0 or frame-error/abort -> one drop write; else bytes in order.
  task automatic rx_frame(input logic [7:0] sc, input logic [7:0] bytes[$]);
    int n;
    n = bytes.size();
    foreach (bytes[i]) m_rx_bytes[i] = bytes[i];
    m_rx_len = 8'(n);
    m_rx_sc  = sc;
    if (n == 0 || sc[2] || sc[3]) exp_wr.push_back({3'd2, 8'h02});
    else foreach (bytes[i]) exp_rx.push_back({sc[4] && (i == n - 1), i == n - 1, bytes[i]});
    frame_seq++;
  endtask

  // stop_after > 0 sends only that many bytes with no tx_last (frame left open).
  task automatic tx_frame(input logic [7:0] bytes[$], input bit bubbles, input int stop_after);
    int n, w;
    n = (stop_after > 0) ? stop_after : bytes.size();
    for (int i = 0; i < n; i++) if (i < int'(MAXLEN)) exp_wr.push_back({3'd1, bytes[i]});
    if (stop_after == 0) begin
      exp_wr.push_back({3'd0, 8'h02});
      if (n > int'(MAXLEN)) exp_lenerr++;
    end
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = bytes[i];
      tx_last  = (stop_after == 0) && (i == n - 1);
      w = 0;
      @(negedge Clk);
      while (!tx_ready && w < 2000) begin
        @(negedge Clk);
        w++;
      end
      if (!tx_ready) begin
        chk(1'b0, "tx_ready_timeout", w, 2000);
        break;
      end
      @(posedge Clk); #1;
      if (bubbles && ($urandom % 4 == 0)) begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #1;
      end
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] q[$];
    logic [7:0] scs[5];
    logic [7:0] held;
    int first0, first3, base, w;
    scs = '{8'h01, 8'h05, 8'h09, 8'h11, 8'h03};
    tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk({Address, WriteEnable, ReadEnable, DataIn, tx_ready, rx_valid, rx_data,
         rx_last, rx_err, tx_len_err, busy} == 27'd0, "reset_outputs",
        {Address, WriteEnable, ReadEnable, DataIn, tx_ready, rx_valid, busy}, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;

    // Both sides pending, Tx_Done=0: RX first, then a TX status read with no writes.
    m_tx_sc = 8'h00;
    tx_valid = 1'b1; tx_data = 8'h55;
    q = '{8'h77};
    rx_frame(8'h01, q);
    wait_drain("both_pending");
    first0 = -1; first3 = -1;
    foreach (rd_log[i]) begin
      if (rd_log[i] == 3'd0 && first0 < 0) first0 = i;
      if (rd_log[i] == 3'd3 && first3 < 0) first3 = i;
    end
    chk(rd_log.size() > 0 && rd_log[0] == 3'd2, "first_poll_rx", rd_log.size() > 0 ? rd_log[0] : 7, 2);
    chk(first3 >= 0 && first0 > first3, "rx_before_tx", first0, first3);
    chk(txr_cnt == 0, "no_tx_ready_when_not_done", txr_cnt, 0);
    tx_valid = 1'b0;
    settle();
    m_tx_sc = 8'h01;

    q = '{8'hA1, 8'hB2, 8'hC3};
    rx_frame(8'h01, q);
    wait_drain("rx_basic");

    base = rd3_cnt;
    rx_frame(8'h05, q);
    wait_drain("rx_drop");
    chk(rd3_cnt == base, "drop_no_buff_reads", rd3_cnt - base, 0);

    q.delete();
    rx_frame(8'h01, q);
    wait_drain("rx_len0");

    q = '{8'h5A, 8'h6B};
    rx_frame(8'h11, q);
    wait_drain("rx_overflow");

    q = '{8'h11, 8'h22, 8'h33};
    tx_frame(q, 1'b0, 0);
    wait_drain("tx_basic");

    q.delete();
    for (int i = 0; i < 130; i++) q.push_back(8'(i + 1));
    tx_frame(q, 1'b0, 0);
    wait_drain("tx_trunc");

    q.delete();
    for (int i = 0; i < int'(MAXLEN); i++) q.push_back(8'(255 - i));
    tx_frame(q, 1'b0, 0);
    wait_drain("tx_exact_max");

    // Back-pressure: output byte must hold and no further Rx_Buff reads while stalled.
    rdy_hold = 1'b1;
    @(posedge Clk); #2;
    q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    rx_frame(8'h01, q);
    w = 0;
    @(negedge Clk);
    while (!rx_valid && w < 500) begin
      @(negedge Clk);
      w++;
    end
    chk(rx_valid, "stall_rx_valid_seen", rx_valid, 1);
    held = rx_data;
    base = rd3_cnt;
    repeat (10) begin
      @(negedge Clk);
      chk(rx_valid && rx_data == held, "stall_hold", {rx_valid, rx_data}, {1'b1, held});
    end
    chk(rd3_cnt == base, "stall_no_reads", rd3_cnt - base, 0);
    rdy_hold = 1'b0;
    wait_drain("rx_stall");

    // Reset in the middle of a TX frame: no TX_GO write afterwards.
    q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    tx_frame(q, 1'b0, 3);
    wait_drain("tx_pre_reset");
    Rst = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    chk(!busy && !tx_ready && !WriteEnable, "reset_midframe", {busy, tx_ready, WriteEnable}, 0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    settle();
    q = '{8'hF0, 8'hF1};
    tx_frame(q, 1'b1, 0);
    wait_drain("tx_after_reset");

    rdy_rand = 1'b1;
    for (int it = 0; it < 16; it++) begin
      q.delete();
      if ($urandom % 2 == 0) begin
        for (int i = 0; i < int'($urandom_range(0, 6)); i++) q.push_back(8'($urandom));
        rx_frame(scs[$urandom_range(0, 4)], q);
        wait_drain("rand_rx");
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 8)); i++) q.push_back(8'($urandom));
        tx_frame(q, 1'b1, 0);
        wait_drain("rand_tx");
      end
    end
    rdy_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
